control_unit: RTL

Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU. It owns PC, IR, ACC and the Z/C flags. It fetches from the 16-entry instruction ROM and drives the data-memory port (address, ACC write value, mem_read, mem_write). It sits directly upstream of data_memory and consumes that block's combinational read data.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_alu.sv | 35 +++
 rtl/control_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states, default widths.
// Helper predicates classify opcodes for memory-read and ACC-write decode.
package cpu_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int OPC_W      = 4;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_STA = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h9;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  function automatic logic reads_mem(input logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic writes_acc(input logic [OPC_W-1:0] op);
    return reads_mem(op) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the accumulator CPU; zero latency, no flow control.
// carry_out is meaningful only for ADD (carry) and SUB (borrow).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero_out
);

  logic [DATA_W:0] wide;

  // One extra bit so ADD carry and SUB borrow both land in the MSB.
  always_comb begin
    wide = {1'b0, acc};
    case (opcode)
      OP_ADD:         wide = {1'b0, acc} + {1'b0, operand};
      OP_SUB:         wide = {1'b0, acc} - {1'b0, operand};
      OP_AND:         wide = {1'b0, acc & operand};
      OP_OR:          wide = {1'b0, acc | operand};
      OP_LDA, OP_LDI: wide = {1'b0, operand};
      default:        wide = {1'b0, acc};
    endcase
  end

  assign result    = wide[DATA_W-1:0];
  assign carry_out = wide[DATA_W];
  assign zero_out  = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction, memory enables decoded from state+IR.
// Optional SINGLE_STEP_EN adds a step input that holds FETCH until step is sampled high.
module control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_acc,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              zero,
  output logic              carry,
  output logic              halted
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] acc_q;
  logic              z_q;
  logic              c_q;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_operand;
  logic [DATA_W-1:0] acc_d;
  logic              c_d;
  logic              z_d;
  logic              advance;
  logic              in_mem_phase;

`ifdef SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  assign opcode       = ir_q[DATA_W-1 -: OPC_W];
  assign operand      = ir_q[ADDR_W-1:0];
  assign in_mem_phase = (state_q == ST_DECODE) || (state_q == ST_EXECUTE);
  assign alu_operand  = (opcode == OP_LDI) ? {{(DATA_W-ADDR_W){1'b0}}, operand} : mem_data;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .acc       (acc_q),
    .operand   (alu_operand),
    .opcode    (opcode),
    .result    (acc_d),
    .carry_out (c_d),
    .zero_out  (z_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      acc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (advance) begin
            ir_q    <= instr_data;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: state_q <= ST_EXECUTE;
        ST_EXECUTE: begin
          state_q <= (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
          if (writes_acc(opcode)) begin
            acc_q <= acc_d;
            z_q   <= z_d;
          end
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) c_q <= c_d;
          if ((opcode == OP_JMP) || ((opcode == OP_JZ) && z_q)) pc_q <= operand;
        end
        ST_HALT: state_q <= ST_HALT;
      endcase
    end
  end

  // Enables are combinational so reset assertion clears them without waiting for a clock.
  assign mem_read   = in_mem_phase && reads_mem(opcode);
  assign mem_write  = (state_q == ST_EXECUTE) && (opcode == OP_STA);
  assign mem_addr   = in_mem_phase ? operand : '0;
  assign mem_acc    = acc_q;
  assign instr_addr = pc_q;
  assign acc_out    = acc_q;
  assign pc_out     = pc_q;
  assign zero       = z_q;
  assign carry      = c_q;
  assign halted     = (state_q == ST_HALT);

endmodule
